// File: rtl/lcd_pkg.sv
// Timing defaults, state encoding and the stored pixel word layout shared by
// the LCD scan driver and its pixel FIFO.
package lcd_pkg;
  localparam int H_ACTIVE = 480;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 41;
  localparam int H_BP     = 2;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE = 272;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 10;
  localparam int V_BP     = 2;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int RGB_W = 8;
  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  typedef struct packed {
    logic                 sof;
    logic [3*RGB_W-1:0]   rgb;
  } pix_t;
endpackage

// File: rtl/lcd_pix_fifo.sv
// Synchronous pixel FIFO with one-cycle flush; head word visible combinationally.
// Push ignored when full, pop ignored when empty; flush drops a same-cycle push.
module lcd_pix_fifo
  import lcd_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  pix_t wdat_i,
  input  logic pop_i,
  input  logic flush_i,
  output pix_t rdat_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = $clog2(DEPTH);

  pix_t          mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdat_o  = mem_q[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdat_i;
  end
endmodule

// File: rtl/lcd_scan_driver.sv
// Raster timing source for an RGB LCD: pops one FIFO word per active pixel.
// Outputs lag the raster counters by one clock; upstream stalls only when the FIFO is full.
module lcd_scan_driver #(
  parameter int H_ACTIVE   = lcd_pkg::H_ACTIVE,
  parameter int H_FP       = lcd_pkg::H_FP,
  parameter int H_SYNC     = lcd_pkg::H_SYNC,
  parameter int H_BP       = lcd_pkg::H_BP,
  parameter int V_ACTIVE   = lcd_pkg::V_ACTIVE,
  parameter int V_FP       = lcd_pkg::V_FP,
  parameter int V_SYNC     = lcd_pkg::V_SYNC,
  parameter int V_BP       = lcd_pkg::V_BP,
  parameter int FIFO_DEPTH = 16,
  parameter logic [3*lcd_pkg::RGB_W-1:0] ERR_RGB = 24'h0000FF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [23:0] s_data,
  input  logic        s_sof,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        de,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        frame_start,
  output logic        underflow
);
  import lcd_pkg::*;

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  state_e           state_q, state_d;
  logic             h_last, frame_last, active_c, origin_c, hsync_c, vsync_c;
  logic             push, pop, flush, err;
  logic             full, empty, rdy_en_q;
  pix_t             head, wdat;
  logic [3*RGB_W-1:0] rgb_c;

  logic [CNT_W-1:0] x_q, y_q;
  logic [RGB_W-1:0] r_q, g_q, b_q;
  logic             de_q, hsync_n_q, vsync_n_q, fs_q, uf_q;

  assign h_last     = (h_q == CNT_W'(HT - 1));
  assign frame_last = h_last && (v_q == CNT_W'(VT - 1));
  assign active_c   = (h_q < CNT_W'(H_ACTIVE)) && (v_q < CNT_W'(V_ACTIVE));
  assign origin_c   = (h_q == '0) && (v_q == '0);
  assign hsync_c    = (h_q >= CNT_W'(H_ACTIVE + H_FP)) && (h_q < CNT_W'(H_ACTIVE + H_FP + H_SYNC));
  assign vsync_c    = (v_q >= CNT_W'(V_ACTIVE + V_FP)) && (v_q < CNT_W'(V_ACTIVE + V_FP + V_SYNC));

  always_comb begin
    h_d = h_last ? '0 : h_q + 1'b1;
    v_d = v_q;
    if (h_last) v_d = (v_q == CNT_W'(VT - 1)) ? '0 : v_q + 1'b1;
  end

  // s_ready is held low through reset and for the release cycle itself.
  assign s_ready  = rdy_en_q && !full;
  assign push     = s_valid && s_ready;
  assign wdat.sof = s_sof;
  assign wdat.rgb = s_data;

  lcd_pix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdat_i  (wdat),
    .pop_i   (pop),
    .flush_i (flush),
    .rdat_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    flush   = 1'b0;
    err     = 1'b0;
    rgb_c   = '0;
    case (state_q)
      ST_WAIT: begin
        // Hunt for a start-of-frame word; it stays at the head until the frame wrap.
        if (!empty && !head.sof) pop = 1'b1;
        if (frame_last && !empty && head.sof) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (active_c) begin
          if (empty) begin
            err = 1'b1;
          end else begin
            pop = 1'b1;
            if (head.sof && !origin_c) err = 1'b1;
            else                       rgb_c = head.rgb;
          end
          if (err) begin
            rgb_c   = ERR_RGB;
            state_d = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        if (active_c) rgb_c = ERR_RGB;
        if (frame_last) begin
          flush   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q       <= '0;
      v_q       <= '0;
      state_q   <= ST_WAIT;
      rdy_en_q  <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      de_q      <= 1'b0;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
      fs_q      <= 1'b0;
      uf_q      <= 1'b0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      state_q   <= state_d;
      rdy_en_q  <= 1'b1;
      x_q       <= active_c ? h_q : '0;
      y_q       <= active_c ? v_q : '0;
      r_q       <= rgb_c[3*RGB_W-1:2*RGB_W];
      g_q       <= rgb_c[2*RGB_W-1:RGB_W];
      b_q       <= rgb_c[RGB_W-1:0];
      de_q      <= active_c;
      hsync_n_q <= !hsync_c;
      vsync_n_q <= !vsync_c;
      fs_q      <= origin_c;
      uf_q      <= uf_q || err;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign de          = de_q;
  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;
endmodule

// File: doc/lcd_scan_driver.md
Name: lcd_scan_driver

Overview:
- Source end of the LCD pixel interface: generates raster timing for a 480x272 panel and drives x, y, r, g, b, de and the syncs into the LCD model/panel.
- Pixel data arrives from an upstream frame source over a valid/ready stream with a start-of-frame flag.
- Data is buffered in a small FIFO and popped one word per active pixel, with underflow detection and frame resynchronisation.

Parameters:
- H_ACTIVE, 480, visible pixels per line
- H_FP, 2, horizontal front porch (clocks)
- H_SYNC, 41, hsync width
- H_BP, 2, horizontal back porch
- V_ACTIVE, 272, visible lines
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 10, vsync width
- V_BP, 2, vertical back porch
- FIFO_DEPTH, 16, pixel FIFO entries (power of 2, >=4)
- ERR_RGB, 24'h0000FF, colour shown after underflow

Ports:
- clk, in, 1, pixel clock
- rst_n, in, 1, reset, asynchronous, active-low
- s_valid, in, 1, upstream pixel valid
- s_ready, out, 1, FIFO can accept
- s_data, in, 24, {r,g,b}, 8 bits each
- s_sof, in, 1, word is pixel (0,0) of a frame
- x, out, 10, active column
- y, out, 10, active row
- r, out, 8, red
- g, out, 8, green
- b, out, 8, blue
- de, out, 1, data enable
- hsync_n, out, 1, horizontal sync, active-low
- vsync_n, out, 1, vertical sync, active-low
- frame_start, out, 1, one-cycle pulse with pixel (0,0)
- underflow, out, 1, sticky error flag; cleared only by reset

Behaviour:
- Raster counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters = 525. v_cnt runs 0..V_TOTAL-1 = 286.
  - v_cnt increments when h_cnt wraps; both wrap to 0 together at the end of the frame.
- Each line/frame is ordered active, front porch, sync, back porch.
  - hsync_n=0 for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync_n=0 for the analogous v_cnt range.
- Outputs are registered, one clock after the counter value they describe.
  - de=1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE. When de=1, x=h_cnt and y=v_cnt; otherwise x=y=0 and r=g=b=0.
- Reset values: counters 0, state WAIT, FIFO empty, x=y=r=g=b=0, de=0, hsync_n=vsync_n=1, frame_start=0, underflow=0, s_ready=0.
  - s_ready goes high from the first cycle after reset release.
- FIFO:
  - Write when s_valid && s_ready; s_ready = !full.
  - Each word is stored as 25 bits {sof, data}.
  - A simultaneous push and pop when full is not allowed, because s_ready is already 0.
  - A push and pop in the same cycle leaves the count unchanged.
- State machine:
  - WAIT:
    - Outputs black during active pixels.
    - Every cycle, pops a head word whose sof=0 (discard).
    - A head word with sof=1 is retained.
    - At h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1, if the head word has sof=1, go to RUN. Otherwise stay in WAIT.
  - RUN:
    - Pops exactly one word per de cycle; r/g/b take that word.
    - Error, set when either condition holds:
      - FIFO is empty at a de cycle (underflow).
      - The popped word has sof=1 at a pixel other than (0,0) (misalignment).
    - On error: set underflow, go to ERR.
  - ERR:
    - Outputs ERR_RGB for all remaining active pixels of the frame; pops nothing.
    - At the frame wrap, flushes the FIFO in one cycle and enters WAIT.
- frame_start is asserted with the registered output of pixel (0,0) in every state.
- Reset mid-frame returns to the reset state immediately; in-flight FIFO data is lost.

Decomposition:
- Package (lcd_pkg):
  - Timing defaults: H_*, V_*, H_TOTAL, V_TOTAL.
  - State encoding WAIT/RUN/ERR.
  - RGB field width of 8.
- Sub-module: lcd_pix_fifo, a synchronous FIFO of FIFO_DEPTH x 25 bits with full, empty and a flush input.
- Counters, syncs and the state machine remain in lcd_scan_driver.

Test Plan:
- Reset released, no input -> hsync_n low for 41 clocks every 525; vsync_n low for 10 lines every 286×525 clocks; de high 480 clocks per line for 272 lines; r=g=b=0.
- Continuous frames of 130560 words, first word sof=1, pixel value = {x[7:0],y[7:0],8'hA5} -> from the second frame, every de cycle shows the matching x, y and RGB; underflow stays 0.
- Upstream stalls 600 clocks mid-line 100 -> underflow=1; ERR_RGB shown from the first starved pixel to the end of the frame; a clean frame resumes after the next sof.
- 5 junk words with sof=0, then a valid frame -> junk discarded in WAIT; first displayed pixel (0,0) equals the sof word.
- sof=1 injected at word 1000 of a frame -> error at x=40, y=2 (word 1000 = 2×480+40); ERR_RGB for the rest of that frame; resync at the following frame.
- rst_n pulsed low at h_cnt=200, v_cnt=50 -> outputs immediately at reset values; timing restarts from (0,0) one frame later than the upstream source.
